bus_cycle_unit: RTL and testbench
=================================

# bus_cycle_unit

Parametrised multiplexed-bus machine-cycle sequencer for the 8085-style core. It turns single-word read/write/opcode-fetch requests from the decoding block into T1/T2/TW/T3 bus cycles with address latch enable, status lines and strobes. Over the fixed 8-bit glue in the top level, it adds:
- generalised address/data widths;
- READY-driven wait states with a timeout;
- HOLD/HLDA bus release;
- back-to-back cycles.

It sits between the core (decoding, register file) and the pads.

## Interface
Parameters:
- AW, 16, total address width; must satisfy AW > DW.
- DW, 8, data width; equals the width of the multiplexed low address/data bus.
- MAX_WAIT, 15, maximum TW states before timeout; must be ≥ 1.

Ports:
- phi1  in  1  single clock; all state changes on its rising edge.
- resetn_in  in  1  reset, asynchronous, active-low.
- req  in  1  cycle request; held until done.
- req_we  in  1  1 = write, 0 = read.
- req_io  in  1  1 = I/O space, 0 = memory.
- req_opf  in  1  opcode fetch (read only; ignored if req_we).
- req_addr  in  AW  cycle address.
- req_wdata  in  DW  write data.
- busy  out  1  cycle in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  DW  captured read data.
- timeout  out  1  sticky; set when wait limit is hit, cleared on next accepted req.
- ready  in  1  pad READY, sampled in T2/TW.
- hold  in  1  bus hold request.
- hlda  out  1  hold acknowledge.
- haddress  out  AW-DW  upper address.
- ad_out  out  DW  multiplexed address/data out.
- ad_in  in  DW  multiplexed bus in.
- ad_oe  out  1  ad_out pad enable.
- ctrl_oe  out  1  enable for haddress, RDn, WRn, IOMn, ALE.
- ALE, RDn, WRn, IOMn, S0, S1  out  1 each  bus control/status.

## Operation
- States: IDLE, T1, T2, TW, T3, HOLD. All outputs are registered.
- Reset values: state IDLE; ALE=0; RDn=1; WRn=1; IOMn=0; S1=S0=0; ad_oe=0; ctrl_oe=1; haddress=0; ad_out=0; busy=done=hlda=timeout=0; rdata=0.
- Status encoding: opcode fetch S1S0=11, read 10, write 01, idle/hold 00. IOMn=req_io.
- Request latching: request fields are latched when the request is accepted.
- IDLE:
  - hold=1 → HOLD (priority over req).
  - else req=1 → T1.
- T1:
  - ALE=1; ad_oe=1; ad_out=addr[DW-1:0]; haddress=addr[AW-1:DW]; status and IOMn valid; busy=1.
- T2:
  - ALE=0.
  - Read: RDn=0, ad_oe=0.
  - Write: WRn=0, ad_out=wdata, ad_oe=1.
  - ready=1 → T3; else → TW with wait count=1.
- TW:
  - Strobes held.
  - ready=1 → T3.
  - Wait count = MAX_WAIT with ready=0 → set timeout, go to T3 anyway.
  - Otherwise count+1.
- T3:
  - Strobes still asserted.
  - At the T3-ending edge: rdata ← ad_in (reads only); RDn/WRn → 1; done=1 for the following cycle.
  - Next state: hold=1 → HOLD; else req=1 (a new request) → T1 (back-to-back); else → IDLE. busy drops only on return to IDLE/HOLD.
- HOLD:
  - hlda=1; ad_oe=0; ctrl_oe=0; strobes=1; S=00.
  - hold=0 → IDLE with hlda=0 on the same edge.
- Mid-cycle hold: hold asserted mid-cycle is not honoured until the T3 boundary.
- Write data: rdata is unchanged by writes.
- Asynchronous reset mid-cycle: immediately forces reset values. The in-flight cycle is dropped without done.

## Timing
- Zero-wait read/write: T1, T2, T3 = 3 cycles; done in the 4th cycle after the accept edge.
- Accept: req sampled high in IDLE at edge E → T1 in cycle E+1.
- Each TW adds 1 cycle. Worst case is 3+MAX_WAIT cycles.
- Back-to-back: the T1 of the next cycle coincides with the done pulse of the previous one.
- Hold latency: hlda rises ≤ 1 cycle after hold in IDLE, or on the edge ending T3 of the active cycle.

## Test plan
- Read, zero wait: AW=16, DW=8, req_addr=0x12A5, ready=1, ad_in=0x3C → T1 ALE=1 ad_out=A5 haddress=12 S=10; RDn low for T2–T3; done on cycle 4 with rdata=3C.
- Write, 2 waits: req_we=1, addr=0x8001, wdata=0x5A, ready low for 2 samples → WRn low 4 cycles, ad_out=5A with ad_oe=1, done on cycle 6, timeout=0.
- Timeout: MAX_WAIT=3, ready stuck 0 → 3 TW then T3, timeout=1, done asserted; timeout clears on next accepted req.
- Hold: hold=1 in IDLE with req=1 → hlda=1 next cycle, ctrl_oe=ad_oe=0, no T1. Hold released → T1 follows. Hold raised in TW → hlda only after T3.
- Back-to-back opcode fetch: two req_opf reads held continuously → S=11, second T1 in the same cycle as the first done, busy stays 1.
- Reset mid-cycle: resetn_in low during TW → all outputs at reset values asynchronously, no done; after release, a new req completes normally.

Source files
------------

// File: rtl/bus_cycle_unit.sv
// rtl/bus_cycle_unit.sv - multiplexed-bus T-state sequencer with wait states, hold and back-to-back cycles
module bus_cycle_unit #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic               phi1,
    input  logic               resetn_in,
    input  logic               req,
    input  logic               req_we,
    input  logic               req_io,
    input  logic               req_opf,
    input  logic [AW-1:0]      req_addr,
    input  logic [DW-1:0]      req_wdata,
    output logic               busy,
    output logic               done,
    output logic [DW-1:0]      rdata,
    output logic               timeout,
    input  logic               ready,
    input  logic               hold,
    output logic               hlda,
    output logic [AW-DW-1:0]   haddress,
    output logic [DW-1:0]      ad_out,
    input  logic [DW-1:0]      ad_in,
    output logic               ad_oe,
    output logic               ctrl_oe,
    output logic               ALE,
    output logic               RDn,
    output logic               WRn,
    output logic               IOMn,
    output logic               S0,
    output logic               S1
);

    localparam int             WCW        = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3,
        ST_HOLD
    } state_t;

    state_t         state, state_nx;
    logic [WCW-1:0] wait_cnt, wait_cnt_nx;
    logic           accept;
    logic           wait_expired;

    // Only direction and write data are needed past T1; address and
    // status are captured straight into their output registers at T1.
    logic           lat_we;
    logic [DW-1:0]  lat_wdata;

    logic           strobe_nx;
    logic           busy_nx;
    logic           rdn_nx;
    logic           wrn_nx;
    logic           ad_oe_nx;
    logic [DW-1:0]  ad_out_nx;
    logic [AW-DW-1:0] haddress_nx;
    logic           iomn_nx;
    logic [1:0]     status_nx;

    // Next-state logic: hold wins over a new request at every boundary
    always_comb begin
        state_nx     = state;
        wait_cnt_nx  = wait_cnt;
        accept       = 1'b0;
        wait_expired = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (hold) begin
                    state_nx = ST_HOLD;
                end else if (req) begin
                    state_nx = ST_T1;
                    accept   = 1'b1;
                end
            end
            ST_T1: state_nx = ST_T2;
            ST_T2: begin
                if (ready) begin
                    state_nx = ST_T3;
                end else begin
                    state_nx    = ST_TW;
                    wait_cnt_nx = WAIT_ONE;
                end
            end
            ST_TW: begin
                if (ready) begin
                    state_nx = ST_T3;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_nx     = ST_T3;
                    wait_expired = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + WAIT_ONE;
                end
            end
            ST_T3: begin
                if (hold) begin
                    state_nx = ST_HOLD;
                end else if (req) begin
                    state_nx = ST_T1;
                    accept   = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!hold) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values of the registered pad outputs, derived from the state being entered
    always_comb begin
        strobe_nx   = (state_nx == ST_T2) || (state_nx == ST_TW) || (state_nx == ST_T3);
        busy_nx     = (state_nx == ST_T1) || strobe_nx;
        rdn_nx      = !(strobe_nx && !lat_we);
        wrn_nx      = !(strobe_nx && lat_we);
        ad_oe_nx    = 1'b0;
        ad_out_nx   = ad_out;
        haddress_nx = haddress;
        iomn_nx     = IOMn;
        status_nx   = {S1, S0};
        if (state_nx == ST_T1) begin
            ad_oe_nx    = 1'b1;
            ad_out_nx   = req_addr[DW-1:0];
            haddress_nx = req_addr[AW-1:DW];
            iomn_nx     = req_io;
            if (req_we)       status_nx = 2'b01;
            else if (req_opf) status_nx = 2'b11;
            else              status_nx = 2'b10;
        end else if (strobe_nx) begin
            ad_oe_nx = lat_we;
            if (state_nx == ST_T2 && lat_we) ad_out_nx = lat_wdata;
        end
        if (!busy_nx) status_nx = 2'b00;
    end

    // State, wait counter and latched request fields
    always_ff @(posedge phi1 or negedge resetn_in) begin
        if (!resetn_in) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (accept) begin
                lat_we    <= req_we;
                lat_wdata <= req_wdata;
            end
        end
    end

    // Registered bus outputs and cycle results
    always_ff @(posedge phi1 or negedge resetn_in) begin
        if (!resetn_in) begin
            ALE      <= 1'b0;
            RDn      <= 1'b1;
            WRn      <= 1'b1;
            IOMn     <= 1'b0;
            S1       <= 1'b0;
            S0       <= 1'b0;
            ad_oe    <= 1'b0;
            ctrl_oe  <= 1'b1;
            haddress <= '0;
            ad_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hlda     <= 1'b0;
            timeout  <= 1'b0;
            rdata    <= '0;
        end else begin
            ALE      <= (state_nx == ST_T1);
            RDn      <= rdn_nx;
            WRn      <= wrn_nx;
            IOMn     <= iomn_nx;
            {S1, S0} <= status_nx;
            ad_oe    <= ad_oe_nx;
            ctrl_oe  <= (state_nx != ST_HOLD);
            haddress <= haddress_nx;
            ad_out   <= ad_out_nx;
            busy     <= busy_nx;
            done     <= (state == ST_T3);
            hlda     <= (state_nx == ST_HOLD);
            if (accept)            timeout <= 1'b0;
            else if (wait_expired) timeout <= 1'b1;
            if (state == ST_T3 && !lat_we) rdata <= ad_in;
        end
    end

endmodule

// File: tb/tb_bus_cycle_unit.sv
// tb/tb_bus_cycle_unit.sv - scoreboard bench for bus_cycle_unit
module tb_bus_cycle_unit;

    logic        phi1 = 1'b0;
    logic        resetn_in, req, req_we, req_io, req_opf, ready, hold;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata, ad_in;
    logic        busy, done, timeout, hlda, ad_oe, ctrl_oe, ALE, RDn, WRn, IOMn, S0, S1;
    logic [7:0]  rdata, ad_out, haddress;

    typedef struct {
        logic [7:0] rdata;
        logic       timeout;
        int         latency;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;

    bus_cycle_unit #(.AW(16), .DW(8), .MAX_WAIT(3)) dut (
        .phi1(phi1), .resetn_in(resetn_in), .req(req), .req_we(req_we), .req_io(req_io),
        .req_opf(req_opf), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
        .done(done), .rdata(rdata), .timeout(timeout), .ready(ready), .hold(hold),
        .hlda(hlda), .haddress(haddress), .ad_out(ad_out), .ad_in(ad_in), .ad_oe(ad_oe),
        .ctrl_oe(ctrl_oe), .ALE(ALE), .RDn(RDn), .WRn(WRn), .IOMn(IOMn), .S0(S0), .S1(S1)
    );

    always #5 phi1 = ~phi1;

    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    task automatic issue(input logic we, input logic io, input logic opf, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_to,
                         input int lat);
        req = 1'b1; req_we = we; req_io = io; req_opf = opf; req_addr = addr; req_wdata = wd;
        sb.push_back(exp_t'{exp_rd, exp_to, lat});
    endtask

    task automatic wait_done(input int budget, inout int cyc);
        while (!done && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        resetn_in = 1'b0; req = 0; req_we = 0; req_io = 0; req_opf = 0; req_addr = 0;
        req_wdata = 0; ad_in = 0; ready = 1; hold = 0;
        tick(); tick();
        vectors++;
        if ({ALE, RDn, WRn, IOMn, S1, S0, ad_oe, ctrl_oe, busy, done, hlda, timeout} !== 12'b011000010000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 011000010000",
                     {ALE, RDn, WRn, IOMn, S1, S0, ad_oe, ctrl_oe, busy, done, hlda, timeout});
        end
        vectors++;
        if ({haddress, ad_out, rdata} !== 24'h0) begin
            miscompares++; $display("FAIL reset_data got %h want 000000", {haddress, ad_out, rdata});
        end
        resetn_in = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || ALE !== 1'b0) begin
            miscompares++; $display("FAIL idle_after_reset got busy=%b ALE=%b want 0 0", busy, ALE);
        end
    endtask

    task automatic test_read_zero_wait();
        int cyc;
        ready = 1; ad_in = 8'h3C;
        issue(0, 0, 0, 16'h12A5, 8'h00, 8'h3C, 0, 4);
        tick(); cyc = 1; req = 0;
        vectors++;
        if ({ALE, ad_oe, busy, S1, S0, ad_out, haddress} !== {5'b11110, 8'hA5, 8'h12}) begin
            miscompares++;
            $display("FAIL read_t1 got %b %h %h want 11110 a5 12", {ALE, ad_oe, busy, S1, S0}, ad_out, haddress);
        end
        tick(); cyc++;
        vectors++;
        if ({ALE, RDn, WRn, ad_oe} !== 4'b0010) begin
            miscompares++; $display("FAIL read_t2 got %b want 0010", {ALE, RDn, WRn, ad_oe});
        end
        tick(); cyc++;
        vectors++;
        if (RDn !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL read_t3 got RDn=%b done=%b want 0 0", RDn, done);
        end
        wait_done(12, cyc);
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || cyc !== e.latency || rdata !== e.rdata || timeout !== e.timeout) begin
            miscompares++;
            $display("FAIL read_done got done=%b cyc=%0d rdata=%h to=%b want 1 %0d %h %b",
                     done, cyc, rdata, timeout, e.latency, e.rdata, e.timeout);
        end
        vectors++;
        if (RDn !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL read_release got RDn=%b busy=%b want 1 0", RDn, busy);
        end
        tick();
    endtask

    task automatic test_write_waits();
        int cyc;
        int lows;
        ready = 0; lows = 0;
        issue(1, 0, 0, 16'h8001, 8'h5A, 8'h3C, 0, 6);
        tick(); cyc = 1; req = 0;
        vectors++;
        if ({S1, S0, ad_oe, ad_out, haddress} !== {3'b011, 8'h01, 8'h80}) begin
            miscompares++;
            $display("FAIL write_t1 got %b %h %h want 011 01 80", {S1, S0, ad_oe}, ad_out, haddress);
        end
        while (!done && cyc < 14) begin
            tick(); cyc++;
            if (!WRn) lows++;
            if (cyc == 2) begin
                vectors++;
                if ({ad_oe, ad_out, RDn} !== {1'b1, 8'h5A, 1'b1}) begin
                    miscompares++;
                    $display("FAIL write_data got oe=%b ad=%h RDn=%b want 1 5a 1", ad_oe, ad_out, RDn);
                end
            end
            if (cyc == 4) ready = 1;
        end
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || cyc !== e.latency || rdata !== e.rdata || timeout !== e.timeout) begin
            miscompares++;
            $display("FAIL write_done got done=%b cyc=%0d rdata=%h to=%b want 1 %0d %h %b",
                     done, cyc, rdata, timeout, e.latency, e.rdata, e.timeout);
        end
        vectors++;
        if (lows !== 4) begin
            miscompares++; $display("FAIL write_strobe_len got %0d want 4", lows);
        end
        tick();
    endtask

    task automatic test_timeout();
        int cyc;
        int lows;
        ready = 0; lows = 0; ad_in = 8'h77;
        issue(0, 1, 0, 16'h0040, 8'h00, 8'h77, 1, 7);
        tick(); cyc = 1; req = 0;
        vectors++;
        if (IOMn !== 1'b1) begin
            miscompares++; $display("FAIL io_status got %b want 1", IOMn);
        end
        while (!done && cyc < 14) begin
            tick(); cyc++;
            if (!RDn) lows++;
        end
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || cyc !== e.latency || rdata !== e.rdata || timeout !== e.timeout) begin
            miscompares++;
            $display("FAIL timeout_done got done=%b cyc=%0d rdata=%h to=%b want 1 %0d %h %b",
                     done, cyc, rdata, timeout, e.latency, e.rdata, e.timeout);
        end
        vectors++;
        if (lows !== 5) begin
            miscompares++; $display("FAIL timeout_strobe_len got %0d want 5", lows);
        end
        tick();
        vectors++;
        if (timeout !== 1'b1) begin
            miscompares++; $display("FAIL timeout_sticky got %b want 1", timeout);
        end
        ready = 1; ad_in = 8'h88;
        issue(0, 0, 0, 16'h0041, 8'h00, 8'h88, 0, 4);
        tick(); cyc = 1; req = 0;
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++; $display("FAIL timeout_clear got %b want 0", timeout);
        end
        wait_done(12, cyc);
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || cyc !== e.latency || rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL after_timeout got done=%b cyc=%0d rdata=%h want 1 %0d %h", done, cyc, rdata, e.latency, e.rdata);
        end
        tick();
    endtask

    task automatic test_hold();
        int cyc;
        int early;
        hold = 1; ready = 1; ad_in = 8'h5E;
        req = 1; req_we = 0; req_io = 0; req_opf = 0; req_addr = 16'h3456;
        tick();
        vectors++;
        if ({hlda, ctrl_oe, ad_oe, busy, S1, S0, RDn, WRn} !== 8'b10000011) begin
            miscompares++;
            $display("FAIL hold_enter got %b want 10000011", {hlda, ctrl_oe, ad_oe, busy, S1, S0, RDn, WRn});
        end
        tick(); tick();
        vectors++;
        if (ALE !== 1'b0 || hlda !== 1'b1) begin
            miscompares++; $display("FAIL hold_stay got ALE=%b hlda=%b want 0 1", ALE, hlda);
        end
        hold = 0;
        tick();
        vectors++;
        if (hlda !== 1'b0 || ctrl_oe !== 1'b1 || ALE !== 1'b0) begin
            miscompares++; $display("FAIL hold_exit got hlda=%b oe=%b ALE=%b want 0 1 0", hlda, ctrl_oe, ALE);
        end
        sb.push_back(exp_t'{8'h5E, 1'b0, 4});
        tick(); cyc = 1; req = 0;
        vectors++;
        if (ALE !== 1'b1 || haddress !== 8'h34) begin
            miscompares++; $display("FAIL hold_then_t1 got ALE=%b ha=%h want 1 34", ALE, haddress);
        end
        wait_done(12, cyc);
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || cyc !== e.latency || rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL hold_cycle got done=%b cyc=%0d rdata=%h want 1 %0d %h", done, cyc, rdata, e.latency, e.rdata);
        end
        tick();
        ready = 0; ad_in = 8'h99; early = 0;
        issue(0, 0, 0, 16'h0102, 8'h00, 8'h99, 0, 6);
        tick(); cyc = 1; req = 0;
        while (!done && cyc < 14) begin
            tick(); cyc++;
            if (cyc == 3) hold = 1;
            if (cyc == 4) ready = 1;
            if (!done && hlda) early++;
        end
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || cyc !== e.latency || rdata !== e.rdata || early !== 0) begin
            miscompares++;
            $display("FAIL hold_midcycle got done=%b cyc=%0d rdata=%h early=%0d want 1 %0d %h 0",
                     done, cyc, rdata, early, e.latency, e.rdata);
        end
        vectors++;
        if (hlda !== 1'b1 || busy !== 1'b0 || ctrl_oe !== 1'b0) begin
            miscompares++; $display("FAIL hold_after_t3 got hlda=%b busy=%b oe=%b want 1 0 0", hlda, busy, ctrl_oe);
        end
        hold = 0;
        tick();
        vectors++;
        if (hlda !== 1'b0) begin
            miscompares++; $display("FAIL hold_release got %b want 0", hlda);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int gaps;
        ready = 1; ad_in = 8'hA1; gaps = 0;
        issue(0, 0, 1, 16'h0100, 8'h00, 8'hA1, 0, 4);
        tick(); cyc = 1;
        vectors++;
        if ({S1, S0, ALE} !== 3'b111) begin
            miscompares++; $display("FAIL opf_status got %b want 111", {S1, S0, ALE});
        end
        req_addr = 16'h0101;
        sb.push_back(exp_t'{8'hB2, 1'b0, 7});
        while (sb.size() > 0 && cyc < 20) begin
            tick(); cyc++;
            if (cyc < 7 && !busy) gaps++;
            if (done) begin
                e = sb.pop_front();
                vectors++;
                if (cyc !== e.latency || rdata !== e.rdata) begin
                    miscompares++;
                    $display("FAIL b2b_done got cyc=%0d rdata=%h want %0d %h", cyc, rdata, e.latency, e.rdata);
                end
                if (cyc == 4) begin
                    vectors++;
                    if ({ALE, S1, S0, ad_out} !== {3'b111, 8'h01}) begin
                        miscompares++;
                        $display("FAIL b2b_second_t1 got %b %h want 111 01", {ALE, S1, S0}, ad_out);
                    end
                    req = 0; ad_in = 8'hB2;
                end
            end
        end
        vectors++;
        if (gaps !== 0 || sb.size() !== 0) begin
            miscompares++; $display("FAIL b2b_busy got gaps=%0d pending=%0d want 0 0", gaps, sb.size());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int dones;
        ready = 0; dones = 0;
        issue(1, 1, 0, 16'hC3D4, 8'hE7, 8'h00, 0, 0);
        tick(); req = 0;
        tick(); tick();
        #2 resetn_in = 1'b0;
        #1;
        vectors++;
        if ({ALE, RDn, WRn, IOMn, S1, S0, ad_oe, ctrl_oe, busy, done, hlda, timeout, haddress, ad_out} !==
            {12'b011000010000, 16'h0}) begin
            miscompares++;
            $display("FAIL async_reset got %b %h %h want 011000010000 00 00",
                     {ALE, RDn, WRn, IOMn, S1, S0, ad_oe, ctrl_oe, busy, done, hlda, timeout}, haddress, ad_out);
        end
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dones++;
        end
        resetn_in = 1'b1;
        tick();
        if (done) dones++;
        vectors++;
        if (dones !== 0) begin
            miscompares++; $display("FAIL reset_no_done got %0d want 0", dones);
        end
        ready = 1; ad_in = 8'h4D;
        issue(0, 0, 0, 16'h5A5A, 8'h00, 8'h4D, 0, 4);
        tick(); cyc = 1; req = 0;
        wait_done(12, cyc);
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || cyc !== e.latency || rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL post_reset got done=%b cyc=%0d rdata=%h want 1 %0d %h", done, cyc, rdata, e.latency, e.rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_timeout();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++; $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
